l_parallel_fir: RTL

//  Parametrised L-parallel FIR filter: consumes L new samples per valid cycle, emits L filtered samples.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_mac_lane.sv | 50 +++++
 rtl/l_parallel_fir.sv | 94 +++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: width/latency helpers and default sample types shared by the L-parallel FIR
package fir_pkg;
   function automatic int acc_w(input int din_w, input int coef_w, input int taps);
      return din_w + coef_w + $clog2(taps);
   endfunction

   function automatic int latency(input int taps);
      return 2 + $clog2(taps);
   endfunction

   localparam int DIN_W_DEF  = 16;
   localparam int COEF_W_DEF = 16;
   localparam int TAPS_DEF   = 8;
   localparam int ACC_W_DEF  = acc_w(DIN_W_DEF, COEF_W_DEF, TAPS_DEF);

   typedef logic signed [DIN_W_DEF-1:0]  sample_t;
   typedef logic signed [COEF_W_DEF-1:0] coef_t;
   typedef logic signed [ACC_W_DEF-1:0]  acc_t;
endpackage

// File: rtl/fir_mac_lane.sv
// fir_mac_lane: one output lane -- TAPS registered products summed by a pipelined adder tree
module fir_mac_lane
   import fir_pkg::*;
#(
   parameter int TAPS   = 8,
   parameter int DIN_W  = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = acc_w(DIN_W, COEF_W, TAPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     v_i,
   input  logic [TAPS*DIN_W-1:0]    x_i,
   input  logic [TAPS*COEF_W-1:0]   h_i,
   output logic                     v_o,
   output logic signed [ACC_W-1:0]  y_o
);
   localparam int S = $clog2(TAPS);
   localparam int P = 1 << S;

   logic signed [ACC_W-1:0] p [TAPS];
   logic signed [ACC_W-1:0] t_q [S+1][P];
   logic [S:0]              v_q;

   // full-precision products: operands sign-extended to the accumulator width first
   always_comb
      for (int k = 0; k < TAPS; k++)
         p[k] = ACC_W'($signed(x_i[k*DIN_W +: DIN_W])) * ACC_W'($signed(h_i[k*COEF_W +: COEF_W]));

   // product stage then halving adder stages; each stage only loads when its data is valid so dout holds in bubbles
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v_q <= '0;
         for (int s = 0; s <= S; s++)
            for (int k = 0; k < P; k++)
               t_q[s][k] <= '0;
      end else begin
         v_q <= {v_q[S-1:0], v_i};
         if (v_i)
            for (int k = 0; k < TAPS; k++)
               t_q[0][k] <= p[k];
         for (int s = 1; s <= S; s++)
            if (v_q[s-1])
               for (int k = 0; k < P/2; k++)
                  t_q[s][k] <= t_q[s-1][2*k] + t_q[s-1][2*k+1];
      end

   assign v_o = v_q[S];
   assign y_o = t_q[S][0];
endmodule

// File: rtl/l_parallel_fir.sv
// l_parallel_fir: L samples in / L filtered samples out per valid cycle, double-buffered coefficients
module l_parallel_fir
   import fir_pkg::*;
#(
   parameter  int L      = 2,
   parameter  int TAPS   = 8,
   parameter  int DIN_W  = 16,
   parameter  int COEF_W = 16,
   localparam int ACC_W  = acc_w(DIN_W, COEF_W, TAPS),
   localparam int AW     = $clog2(TAPS),
   localparam int H      = TAPS - 1 + L
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [L*DIN_W-1:0]  din,
   input  logic                clear,
   input  logic                coef_we,
   input  logic [AW-1:0]       coef_addr,
   input  logic [COEF_W-1:0]   coef_data,
   input  logic                coef_commit,
   output logic                out_valid,
   output logic [L*ACC_W-1:0]  dout
);
   logic [DIN_W-1:0]       hist_q [H];
   logic [DIN_W-1:0]       hist_d [H];
   logic [COEF_W-1:0]      shadow_q [TAPS];
   logic [COEF_W-1:0]      shadow_d [TAPS];
   logic [COEF_W-1:0]      active_q [TAPS];
   logic [COEF_W-1:0]      active_d [TAPS];
   logic [COEF_W-1:0]      bank_q [TAPS];
   logic                   v1_q;
   logic [L-1:0]           lane_v;
   logic [TAPS*COEF_W-1:0] h_flat;

   // history index 0 is the newest sample; clear zeroes it before the incoming block is shifted in
   always_comb begin
      for (int k = 0; k < L; k++)
         hist_d[k] = in_valid ? din[(L-1-k)*DIN_W +: DIN_W] : clear ? '0 : hist_q[k];
      for (int k = L; k < H; k++)
         hist_d[k] = clear ? '0 : in_valid ? hist_q[k-L] : hist_q[k];
   end

   // shadow takes writes (out-of-range addresses match no entry); commit copies the pre-write shadow
   always_comb
      for (int j = 0; j < TAPS; j++) begin
         shadow_d[j] = (coef_we && int'(coef_addr) == j) ? coef_data : shadow_q[j];
         active_d[j] = coef_commit ? shadow_q[j] : active_q[j];
      end

   // stage 1: history, coefficient banks, and a per-block snapshot of the bank so in-flight blocks keep theirs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hist_q   <= '{default: '0};
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
         bank_q   <= '{default: '0};
         v1_q     <= 1'b0;
      end else begin
         hist_q   <= hist_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         v1_q     <= in_valid;
         if (in_valid)
            bank_q <= active_d;
      end

   for (genvar j = 0; j < TAPS; j++) begin : g_coef
      assign h_flat[j*COEF_W +: COEF_W] = bank_q[j];
   end

   for (genvar i = 0; i < L; i++) begin : g_lane
      logic [TAPS*DIN_W-1:0] x;
      for (genvar j = 0; j < TAPS; j++) begin : g_tap
         assign x[j*DIN_W +: DIN_W] = hist_q[L-1-i+j];
      end
      fir_mac_lane #(
         .TAPS   (TAPS),
         .DIN_W  (DIN_W),
         .COEF_W (COEF_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .v_i   (v1_q),
         .x_i   (x),
         .h_i   (h_flat),
         .v_o   (lane_v[i]),
         .y_o   (dout[i*ACC_W +: ACC_W])
      );
   end

   assign out_valid = |lane_v;
endmodule
